// File: rtl/wb_protocol_monitor.sv
// wb_protocol_monitor
//   Passive Wishbone B4 protocol checker that taps the bus between the host
//   and the SDRAM controller. Every clock it checks the reset, cycle-start,
//   termination, stability and timeout rules. Each violation is recorded in
//   a sticky flag, a saturating violation-cycle counter and a first-error
//   capture. It supports classic (wait-state) and pipelined (stall and
//   outstanding) bus modes.
//
// Ports
//   wb_clk_i, wb_rst_i      bus clock; synchronous active-high reset. The
//                           reset is also one of the monitored signals.
//   wb_cyc_i ... wb_dat_i   monitored master signals
//   wb_ack_o, wb_err_o,     monitored slave responses (inputs here)
//   wb_stall_o
//   err_clr_i               one-cycle pulse that clears the sticky flags, the
//                           first-error capture and the violation counter
//   irq_mask_i              per-flag enable for irq_o
//   err_sticky_o            sticky flags: 0 STB_NO_CYC, 1 TERM_NO_REQ,
//                           2 RST_BUS, 3 UNSTABLE, 4 TIMEOUT, 5 MULTI_TERM,
//                           6 RST_SHORT, 7 OUTST_OVF
//   err_first_o/_vld_o      index of the first violation since the last clear
//   err_cnt_o               saturating count of cycles with any violation
//   xfer_cnt_o              wrapping count of terminated live requests
//   irq_o                   registered |(err_sticky_o & irq_mask_i)
module wb_protocol_monitor #(
  parameter int APP_AW    = 26,
  parameter int DW        = 32,
  parameter int PIPELINED = 0,
  parameter int TIMEOUT   = 256,
  parameter int MIN_RST   = 1,
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic [APP_AW-1:0] wb_addr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_o,
  input  logic              wb_err_o,
  input  logic              wb_stall_o,
  input  logic              err_clr_i,
  input  logic [7:0]        irq_mask_i,
  output logic [7:0]        err_sticky_o,
  output logic [2:0]        err_first_o,
  output logic              err_first_vld_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  xfer_cnt_o,
  output logic              irq_o
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int OW = (MAX_OUTST > 0) ? $clog2(MAX_OUTST + 1) : 1;
  localparam int RW = (MIN_RST > 0) ? $clog2(MIN_RST + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [OW-1:0] OUTST_MAX  = OW'(MAX_OUTST);
  localparam logic [RW-1:0] RST_MIN    = RW'(MIN_RST);

  localparam int B_STB_NO_CYC  = 0;
  localparam int B_TERM_NO_REQ = 1;
  localparam int B_RST_BUS     = 2;
  localparam int B_UNSTABLE    = 3;
  localparam int B_TIMEOUT     = 4;
  localparam int B_MULTI_TERM  = 5;
  localparam int B_RST_SHORT   = 6;
  localparam int B_OUTST_OVF   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Lowest set index wins when several rules fire in the same cycle.
  function automatic logic [2:0] first_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic              req, term, accept, changed, rst_fell;
  logic              cap_en, held, held_next, unstable;
  logic              run, timeout_hit, xfer_inc;
  logic [TW-1:0]     timer, timer_next;
  logic [OW-1:0]     outst, outst_next;
  logic [RW-1:0]     rst_len;
  logic              rst_p1;
  logic [7:0]        viol;
  logic              cap_we;
  logic [SW-1:0]     cap_sel;
  logic [APP_AW-1:0] cap_addr;
  logic [DW-1:0]     cap_dat;

  assign req      = wb_cyc_i & wb_stb_i;
  assign term     = wb_ack_o | wb_err_o;
  assign accept   = wb_stb_i & ~wb_stall_o;
  assign rst_fell = rst_p1 & ~wb_rst_i;
  assign changed  = (wb_addr_i != cap_addr) | (wb_we_i != cap_we) |
                    (wb_sel_i != cap_sel) | (wb_we_i & (wb_dat_i != cap_dat));

  // Request tracking: the classic FSM or the pipelined stall hold.
  always_comb begin
    state_next = state;
    cap_en     = 1'b0;
    held_next  = 1'b0;
    unstable   = 1'b0;
    if (PIPELINED == 0) begin
      unique case (state)
        IDLE: begin
          if (req & ~term) begin
            state_next = WAIT;
            cap_en     = 1'b1;
          end
        end
        WAIT: begin
          // Termination and abort both return to IDLE; an abort is legal.
          if (term | ~req) state_next = IDLE;
          unstable = req & changed;
        end
        default: state_next = IDLE;
      endcase
    end else begin
      // A stalled request is captured on its first stalled cycle and must stay
      // unchanged up to and including the cycle that accepts it.
      held_next = req & wb_stall_o;
      cap_en    = req & wb_stall_o & ~held;
      unstable  = held & wb_stb_i & changed;
    end
  end

  // Outstanding count, timeout timer and transfer counting.
  always_comb begin
    outst_next  = outst;
    timer_next  = '0;
    timeout_hit = 1'b0;
    if (PIPELINED != 0) begin
      if (accept & ~term) begin
        if (outst != OUTST_MAX) outst_next = outst + OW'(1);
      end else if (~accept & term) begin
        if (outst != '0) outst_next = outst - OW'(1);
      end
      // Dropping CYC abandons everything in flight.
      if (~wb_cyc_i) outst_next = '0;
      run      = (outst != '0) | (wb_stb_i & wb_stall_o);
      xfer_inc = term & ((outst != '0) | accept);
    end else begin
      run      = req;
      xfer_inc = term & req;
    end
    if ((TIMEOUT != 0) && run && !term) begin
      if (timer == TIMER_LAST) timeout_hit = 1'b1;
      else                     timer_next  = timer + TW'(1);
    end
  end

  always_comb begin
    viol                = '0;
    viol[B_STB_NO_CYC]  = wb_stb_i & ~wb_cyc_i;
    viol[B_TERM_NO_REQ] = (PIPELINED != 0) ? (term & (outst == '0) & ~accept)
                                           : (term & ~req);
    viol[B_RST_BUS]     = rst_fell & (wb_cyc_i | wb_stb_i);
    viol[B_UNSTABLE]    = unstable;
    viol[B_TIMEOUT]     = timeout_hit;
    viol[B_MULTI_TERM]  = wb_ack_o & wb_err_o;
    viol[B_RST_SHORT]   = rst_fell & (rst_len < RST_MIN);
    viol[B_OUTST_OVF]   = (PIPELINED != 0) &
                          ((accept & (outst == OUTST_MAX)) | (~wb_cyc_i & (outst != '0)));
  end

  // ---- stage p1: reset history (runs through reset) ----
  always_ff @(posedge wb_clk_i) begin
    rst_p1 <= wb_rst_i;
    if (wb_rst_i) begin
      if (!rst_p1)                rst_len <= RW'(1);
      else if (rst_len < RST_MIN) rst_len <= rst_len + RW'(1);
    end
  end

  // ---- stage p1: captured request (data, no reset) ----
  always_ff @(posedge wb_clk_i) begin
    if (cap_en) begin
      cap_addr <= wb_addr_i;
      cap_we   <= wb_we_i;
      cap_sel  <= wb_sel_i;
      cap_dat  <= wb_dat_i;
    end
  end

  // ---- stage p1: tracking state and reported results ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      held            <= 1'b0;
      outst           <= '0;
      timer           <= '0;
      err_sticky_o    <= '0;
      err_first_o     <= '0;
      err_first_vld_o <= 1'b0;
      err_cnt_o       <= '0;
      xfer_cnt_o      <= '0;
      irq_o           <= 1'b0;
    end else begin
      state      <= state_next;
      held       <= held_next;
      outst      <= outst_next;
      timer      <= timer_next;
      xfer_cnt_o <= xfer_cnt_o + CNT_W'(xfer_inc);
      irq_o      <= |(err_sticky_o & irq_mask_i);
      // A clear in the same cycle as a violation wins; that violation is lost.
      if (err_clr_i) begin
        err_sticky_o    <= '0;
        err_first_o     <= '0;
        err_first_vld_o <= 1'b0;
        err_cnt_o       <= '0;
      end else if (|viol) begin
        err_sticky_o <= err_sticky_o | viol;
        err_cnt_o    <= sat_inc(err_cnt_o);
        if (!err_first_vld_o) begin
          err_first_o     <= first_index(viol);
          err_first_vld_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_protocol_monitor.sv
module tb_wb_protocol_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we, ack, err, stall, clr;
  logic [3:0]  sel;
  logic [25:0] addr;
  logic [31:0] dat;
  logic [7:0]  mask;

  logic [7:0]  c_sticky, p_sticky;
  logic [2:0]  c_first, p_first;
  logic        c_fvld, p_fvld, c_irq, p_irq;
  logic [15:0] c_cnt, p_cnt, c_xfer, p_xfer;

  int checks = 0;
  int errors = 0;

  wb_protocol_monitor #(.PIPELINED(0), .TIMEOUT(16), .MIN_RST(4)) u_classic (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_dat_i(dat), .wb_ack_o(ack), .wb_err_o(err),
    .wb_stall_o(stall), .err_clr_i(clr), .irq_mask_i(mask), .err_sticky_o(c_sticky),
    .err_first_o(c_first), .err_first_vld_o(c_fvld), .err_cnt_o(c_cnt),
    .xfer_cnt_o(c_xfer), .irq_o(c_irq));

  wb_protocol_monitor #(.PIPELINED(1), .MAX_OUTST(2), .MIN_RST(4)) u_pipe (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_dat_i(dat), .wb_ack_o(ack), .wb_err_o(err),
    .wb_stall_o(stall), .err_clr_i(clr), .irq_mask_i(mask), .err_sticky_o(p_sticky),
    .err_first_o(p_first), .err_first_vld_o(p_fvld), .err_cnt_o(p_cnt),
    .xfer_cnt_o(p_xfer), .irq_o(p_irq));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0; err = 1'b0; stall = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus_idle();
    repeat (n) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; mask = 8'h01;
    sel = 4'hf; addr = 26'h100; dat = 32'hdeadbeef;
    bus_idle();

    // Reset state
    repeat (5) tick();
    check("rst_sticky", 32'(c_sticky), 32'h0);
    check("rst_cnt",    32'(c_cnt),    32'h0);
    check("rst_xfer",   32'(c_xfer),   32'h0);
    check("rst_fvld",   32'(c_fvld),   32'h0);
    check("rst_irq",    32'(c_irq),    32'h0);
    rst = 1'b0;
    tick();
    tick();
    check("rst_release_sticky", 32'(c_sticky), 32'h0);

    // 1: classic write, three wait states, ack on the fourth cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 26'h100; dat = 32'hdeadbeef;
    repeat (3) tick();
    ack = 1'b1;
    tick();
    bus_idle();
    tick();
    check("t1_sticky", 32'(c_sticky), 32'h0);
    check("t1_xfer",   32'(c_xfer),   32'h1);
    check("t1_cnt",    32'(c_cnt),    32'h0);

    // 2: STB without CYC
    stb = 1'b1;
    tick();
    stb = 1'b0;
    check("t2_sticky", 32'(c_sticky), 32'h01);
    check("t2_first",  32'(c_first),  32'h0);
    check("t2_fvld",   32'(c_fvld),   32'h1);
    check("t2_cnt",    32'(c_cnt),    32'h1);
    tick();
    check("t2_irq", 32'(c_irq), 32'h1);
    pulse_clr();
    check("t2_clr_sticky", 32'(c_sticky), 32'h0);
    check("t2_clr_cnt",    32'(c_cnt),    32'h0);
    check("t2_clr_fvld",   32'(c_fvld),   32'h0);
    check("t2_clr_xfer",   32'(c_xfer),   32'h1);
    tick();
    check("t2_irq_off", 32'(c_irq), 32'h0);

    // 3: address changes during a wait state
    do_reset(5);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 26'h100;
    tick();
    addr = 26'h104;
    tick();
    check("t3_unstable", 32'(c_sticky), 32'h08);
    check("t3_first",    32'(c_first),  32'h3);
    ack = 1'b1;
    tick();
    bus_idle();
    tick();
    check("t3_xfer", 32'(c_xfer), 32'h1);
    check("t3_cnt",  32'(c_cnt),  32'h2);

    // 4: timeout 16 cycles after the request, then reset mid-wait
    pulse_clr();
    cyc = 1'b1; stb = 1'b1; addr = 26'h200;
    repeat (15) tick();
    check("t4_before_timeout", 32'(c_sticky[4]), 32'h0);
    tick();
    check("t4_timeout", 32'(c_sticky), 32'h10);
    check("t4_first",   32'(c_first),  32'h4);
    rst = 1'b1;
    tick();
    check("t4_rst_sticky", 32'(c_sticky), 32'h0);
    check("t4_rst_xfer",   32'(c_xfer),   32'h0);
    check("t4_rst_cnt",    32'(c_cnt),    32'h0);
    check("t4_rst_fvld",   32'(c_fvld),   32'h0);
    bus_idle();
    repeat (4) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("t4_after_rst", 32'(c_sticky), 32'h0);

    // 5: short reset, CYC high on the first cycle after it falls
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; cyc = 1'b1;
    tick();
    cyc = 1'b0;
    check("t5_sticky", 32'(c_sticky), 32'h44);
    check("t5_first",  32'(c_first),  32'h2);
    check("t5_cnt",    32'(c_cnt),    32'h1);

    // Double termination, then termination with no request
    pulse_clr();
    cyc = 1'b1; stb = 1'b1; ack = 1'b1; err = 1'b1;
    tick();
    bus_idle();
    check("multi_term", 32'(c_sticky), 32'h20);
    check("multi_first", 32'(c_first), 32'h5);
    check("multi_xfer", 32'(c_xfer), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("term_no_req", 32'(c_sticky), 32'h22);
    check("term_no_req_cnt", 32'(c_cnt), 32'h2);

    // 6: pipelined, outstanding overflow and clamping at MAX_OUTST=2
    do_reset(5);
    cyc = 1'b1; stb = 1'b1;
    repeat (2) tick();
    check("t6_two_accepts", 32'(p_sticky), 32'h0);
    tick();
    check("t6_ovf", 32'(p_sticky), 32'h80);
    check("t6_ovf_first", 32'(p_first), 32'h7);
    ack = 1'b1;
    tick();
    stb = 1'b0; ack = 1'b0;
    pulse_clr();
    check("t6_clr_sticky", 32'(p_sticky), 32'h0);
    check("t6_clr_cnt",    32'(p_cnt),    32'h0);
    check("t6_clr_fvld",   32'(p_fvld),   32'h0);
    ack = 1'b1;
    repeat (2) tick();
    check("t6_drain_sticky", 32'(p_sticky), 32'h0);
    check("t6_drain_xfer",   32'(p_xfer),   32'h3);
    tick();
    ack = 1'b0;
    check("t6_extra_ack", 32'(p_sticky), 32'h02);
    check("t6_extra_xfer", 32'(p_xfer), 32'h3);
    cyc = 1'b0;
    tick();
    check("t6_cyc_drop", 32'(p_sticky), 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
